ul_read_axis_mux: RTL

Parametrised successor to the UL-to-AXI-Stream read bridge. It serves UL read-address requests by popping one word from one of N AXI-Stream source ports and returning it on the UL read-data channel. New capabilities:
- per-read timeout with error return
- per-port non-blocking mode
- out-of-range address rejection
- error flag on every response
- saturating timeout statistic

It sits between the UL register bus and the FIFO/status sources that are read on demand.

---
 rtl/ul_read_axis_mux_pkg.sv | 19 +
 rtl/ul_read_axis_mux_if.sv | 36 +++
 rtl/ul_axis_port_mux.sv | 26 ++
 rtl/ul_read_axis_mux.sv | 134 +++++++++++++
 4 files changed

// File: rtl/ul_read_axis_mux_pkg.sv
// Shared types and defaults for the UL-to-AXI-Stream read multiplexer.
package ul_read_axis_mux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NBITS      = 4;
    localparam int DEF_TIMEOUT    = 255;
    localparam int DEF_STAT_WIDTH = 16;

    // Wait-counter width: it only has to reach TIMEOUT-1.
    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/ul_read_axis_mux_if.sv
// UL read channel plus per-port stream handshake, seen from the mux (slave) and its driver (master).
interface ul_read_axis_mux_if
    import ul_read_axis_mux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NBITS      = DEF_NBITS,
    parameter int N          = 1 << NBITS,
    parameter int STAT_WIDTH = DEF_STAT_WIDTH
);
    logic [NBITS-1:0]        s_ul_araddr;
    logic                    s_ul_arvalid;
    logic                    s_ul_arready;
    logic [DATA_WIDTH-1:0]   s_ul_rdata;
    logic                    s_ul_rvalid;
    logic                    s_ul_rready;
    logic                    s_ul_rerr;
    logic [N-1:0]            axis_port_ready;
    logic [N-1:0]            axis_port_valid;
    logic [DATA_WIDTH*N-1:0] axis_port_data;
    logic [NBITS-1:0]        axis_port_addr;
    logic                    axis_port_addr_valid;
    logic [STAT_WIDTH-1:0]   stat_timeouts;

    modport slave (
        input  s_ul_araddr, s_ul_arvalid, s_ul_rready, axis_port_valid, axis_port_data,
        output s_ul_arready, s_ul_rdata, s_ul_rvalid, s_ul_rerr, axis_port_ready,
               axis_port_addr, axis_port_addr_valid, stat_timeouts
    );

    modport master (
        output s_ul_araddr, s_ul_arvalid, s_ul_rready, axis_port_valid, axis_port_data,
        input  s_ul_arready, s_ul_rdata, s_ul_rvalid, s_ul_rerr, axis_port_ready,
               axis_port_addr, axis_port_addr_valid, stat_timeouts
    );

endinterface

// File: rtl/ul_axis_port_mux.sv
// Combinational N:1 selection of stream data and valid by port index.
module ul_axis_port_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 16,
    parameter int SEL_WIDTH  = 4
) (
    input  logic [SEL_WIDTH-1:0]    sel_i,
    input  logic [DATA_WIDTH*N-1:0] data_i,
    input  logic [N-1:0]            valid_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    valid_o
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
        data_o  = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel_i == SEL_WIDTH'(i)) begin
                data_o  = data_i[DATA_WIDTH*i +: DATA_WIDTH];
                valid_o = valid_i[i];
            end
        end
    end

endmodule

// File: rtl/ul_read_axis_mux.sv
// Serves UL reads by popping one word from a selected stream port, with timeout,
// non-blocking ports, out-of-range rejection and a saturating timeout statistic.
module ul_read_axis_mux
    import ul_read_axis_mux_pkg::*;
#(
    parameter int                    DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int                    NBITS         = DEF_NBITS,
    parameter int                    N             = 1 << NBITS,
    parameter int                    TIMEOUT       = DEF_TIMEOUT,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA  = '1,
    parameter logic [N-1:0]          NONBLOCK_MASK = '0,
    parameter int                    STAT_WIDTH    = DEF_STAT_WIDTH
) (
    input  logic          s_ul_clk,
    input  logic          s_ul_reset,
    ul_read_axis_mux_if.slave bus
);

    localparam int               CW  = cnt_width(TIMEOUT);
    localparam logic [NBITS:0]   N_L = (NBITS + 1)'(N);
    localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT - 1);

    state_e                  state_q;
    logic [NBITS-1:0]        sel_q;
    logic [CW-1:0]           cnt_q;
    logic [N-1:0]            port_ready_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    rvalid_q;
    logic                    rerr_q;
    logic [STAT_WIDTH-1:0]   stat_q;

    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_valid;
    logic [N-1:0]            addr_onehot;
    logic                    arready;
    logic                    accept;
    logic                    in_range;
    logic                    transfer;
    logic                    nb_sel;
    logic                    timeout_hit;

    ul_axis_port_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .SEL_WIDTH  (NBITS)
    ) u_port_mux (
        .sel_i   (sel_q),
        .data_i  (bus.axis_port_data),
        .valid_i (bus.axis_port_valid),
        .data_o  (sel_data),
        .valid_o (sel_valid)
    );

    always_comb begin
        addr_onehot = '0;
        for (int i = 0; i < N; i++) begin
            addr_onehot[i] = (bus.s_ul_araddr == NBITS'(i));
        end
    end

    assign arready     = (state_q == ST_IDLE) && (!rvalid_q || bus.s_ul_rready);
    assign accept      = bus.s_ul_arvalid && arready;
    assign in_range    = {1'b0, bus.s_ul_araddr} < N_L;
    // port_ready_q is one-hot on the selected port throughout WAIT.
    assign transfer    = (state_q == ST_WAIT) && (|port_ready_q) && sel_valid;
    assign nb_sel      = |(port_ready_q & NONBLOCK_MASK);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge s_ul_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (s_ul_reset) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            cnt_q        <= '0;
            port_ready_q <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            rerr_q       <= 1'b0;
            stat_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rvalid_q && bus.s_ul_rready) begin
                        rvalid_q <= 1'b0;
                        rerr_q   <= 1'b0;
                    end
                    if (accept) begin
                        if (in_range) begin
                            sel_q        <= bus.s_ul_araddr;
                            port_ready_q <= addr_onehot;
                            cnt_q        <= '0;
                            state_q      <= ST_WAIT;
                        end else begin
                            rdata_q  <= TIMEOUT_DATA;
                            rvalid_q <= 1'b1;
                            rerr_q   <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (transfer) begin
                        port_ready_q <= '0;
                        rdata_q      <= sel_data;
                        rvalid_q     <= 1'b1;
                        rerr_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else if (nb_sel || timeout_hit) begin
                        port_ready_q <= '0;
                        rdata_q      <= TIMEOUT_DATA;
                        rvalid_q     <= 1'b1;
                        rerr_q       <= 1'b1;
                        state_q      <= ST_IDLE;
                        if (stat_q != '1) begin
                            stat_q <= stat_q + STAT_WIDTH'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_ul_arready         = arready;
    assign bus.s_ul_rdata           = rdata_q;
    assign bus.s_ul_rvalid          = rvalid_q;
    assign bus.s_ul_rerr            = rerr_q;
    assign bus.axis_port_ready      = port_ready_q;
    assign bus.axis_port_addr       = sel_q;
    assign bus.axis_port_addr_valid = (state_q == ST_WAIT);
    assign bus.stat_timeouts        = stat_q;

endmodule
